// File: rtl/acorn_encrypt_process.sv
// ---------------------------------------------------------------------------
// acorn_encrypt_process
//
// Bit-serial ACORN-128 encryption stage. Takes the 293-bit state left by the
// associated-data stage and absorbs one plaintext bit per state step. Each
// absorbed bit produces one ciphertext bit. After the last plaintext bit it
// runs the 256-step padding phase. It then holds the resulting state for
// finalization.
//
// Optional feature: define ACORN_DECRYPT_EN to add the 'dec' input. With
// dec=1 the streamed bits are treated as ciphertext and plaintext comes out.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               one-cycle request, honoured only in IDLE/DONE
//   state_in, pt_len    initial state and message bit-length, captured on start
//   pt_bit, pt_valid    input bit stream (valid qualifier)
//   pt_ready            high while the block consumes input bits
//   ct_bit, ct_valid    output bit, valid pulses one cycle after acceptance
//   busy                high during message absorption and padding
//   done                padding complete, state_out is final
//   dec                 (ACORN_DECRYPT_EN only) decrypt mode, captured on start
//   state_out           registered state
// ---------------------------------------------------------------------------
module acorn_encrypt_process #(
    parameter int LEN_W     = 12,
    parameter int PAD_STEPS = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [292:0]     state_in,
    input  logic [LEN_W-1:0] pt_len,
    input  logic             pt_bit,
    input  logic             pt_valid,
`ifdef ACORN_DECRYPT_EN
    input  logic             dec,
`endif
    output logic             pt_ready,
    output logic             ct_bit,
    output logic             ct_valid,
    output logic             busy,
    output logic             done,
    output logic [292:0]     state_out
);

    // The counter is shared by the message phase and the padding phase.
    localparam int CNT_W = (LEN_W > $clog2(PAD_STEPS)) ? LEN_W : $clog2(PAD_STEPS);

    typedef enum logic [1:0] {IDLE, PT, PAD, DONE} fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [292:0]     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ct_bit_q, ct_bit_d;
    logic             ct_valid_q, ct_valid_d;
    logic             done_q, done_d;
    logic             dec_q, dec_d;

    logic             step_m, step_ca, step_ks;
    logic [292:0]     step_next;
    logic [CNT_W-1:0] last_pt_cnt;

    assign last_pt_cnt = CNT_W'(len_q) - CNT_W'(1);

    // Message bits (or decrypted bits) drive the step in PT.
    // The padding schedule drives it in PAD: a single 1 first,
    // then ca stays on for the first half.
    always_comb begin
        step_m  = 1'b0;
        step_ca = 1'b1;
        if (fsm_q == PT) begin
            step_m  = dec_q ? (pt_bit ^ step_ks) : pt_bit;
            step_ca = 1'b1;
        end else begin
            step_m  = (cnt_q == '0);
            step_ca = (cnt_q < CNT_W'(PAD_STEPS / 2));
        end
    end

    // One StateUpdate128 step. The LFSR taps are folded in sequence,
    // and ks is built from the folded taps. ks never depends on m,
    // so step_m may use step_ks without forming a loop. cb is always
    // 0 in this stage.
    always_comb begin
        logic [292:0] s;
        logic         f;
        s      = state_q;
        s[289] = s[289] ^ s[235] ^ s[230];
        s[230] = s[230] ^ s[196] ^ s[193];
        s[193] = s[193] ^ s[160] ^ s[154];
        s[154] = s[154] ^ s[111] ^ s[107];
        s[107] = s[107] ^ s[66]  ^ s[61];
        s[61]  = s[61]  ^ s[23]  ^ s[0];
        step_ks = s[12] ^ s[154]
                ^ ((s[235] & s[61]) ^ (s[235] & s[193]) ^ (s[61] & s[193]))
                ^ ((s[230] & s[111]) ^ (~s[230] & s[66]));
        f = s[0] ^ ~s[107]
          ^ ((s[244] & s[23]) ^ (s[244] & s[160]) ^ (s[23] & s[160]))
          ^ (step_ca & s[196]) ^ step_m;
        step_next = {f, s[292:1]};
    end

    // Next-state logic for the control FSM and the datapath registers.
    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        ct_bit_d   = ct_bit_q;
        ct_valid_d = 1'b0;
        done_d     = done_q;
        dec_d      = dec_q;
        case (fsm_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = state_in;
                    len_d   = pt_len;
                    cnt_d   = '0;
                    done_d  = 1'b0;
`ifdef ACORN_DECRYPT_EN
                    dec_d   = dec;
`else
                    dec_d   = 1'b0;
`endif
                    fsm_d   = (pt_len != '0) ? PT : PAD;
                end
            end
            PT: begin
                if (pt_valid) begin
                    state_d    = step_next;
                    cnt_d      = cnt_q + CNT_W'(1);
                    ct_bit_d   = pt_bit ^ step_ks;
                    ct_valid_d = 1'b1;
                    if (cnt_q == last_pt_cnt) begin
                        fsm_d = PAD;
                        cnt_d = '0;
                    end
                end
            end
            PAD: begin
                state_d = step_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(PAD_STEPS - 1)) begin
                    fsm_d  = DONE;
                    cnt_d  = '0;
                    done_d = 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State registers. The reset is asynchronous, so it aborts any run at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q      <= IDLE;
            state_q    <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            ct_bit_q   <= 1'b0;
            ct_valid_q <= 1'b0;
            done_q     <= 1'b0;
            dec_q      <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            ct_bit_q   <= ct_bit_d;
            ct_valid_q <= ct_valid_d;
            done_q     <= done_d;
            dec_q      <= dec_d;
        end
    end

    assign pt_ready  = (fsm_q == PT);
    assign busy      = (fsm_q == PT) || (fsm_q == PAD);
    assign ct_bit    = ct_bit_q;
    assign ct_valid  = ct_valid_q;
    assign done      = done_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_acorn_encrypt_process.sv
// ---------------------------------------------------------------------------
// tb_acorn_encrypt_process
//
// Self-checking bench for acorn_encrypt_process. Stimulus is randomized:
// random states, random messages, random pt_valid stalls, and stray start
// and pt_valid pulses. The expected ciphertext stream and final state come
// from a bit-array model of ACORN-128 kept in this file.
// ---------------------------------------------------------------------------
module tb_acorn_encrypt_process;

   localparam int LEN_W = 12;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [292:0]     state_in;
   logic [LEN_W-1:0] pt_len;
   logic             pt_bit;
   logic             pt_valid;
`ifdef ACORN_DECRYPT_EN
   logic             dec;
`endif
   logic             pt_ready;
   logic             ct_bit;
   logic             ct_valid;
   logic             busy;
   logic             done;
   logic [292:0]     state_out;

   int checkCount = 0;
   int errorCount = 0;
   int lastEdges;

   bit           ptMsg   [4096];
   bit           expCt   [4096];
   bit           savedPt [4096];
   bit           savedCt [4096];
   logic [292:0] expFinal;
   logic [292:0] savedState;
   logic [292:0] savedFinal;

   acorn_encrypt_process #(.LEN_W(LEN_W), .PAD_STEPS(256)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .state_in  (state_in),
      .pt_len    (pt_len),
      .pt_bit    (pt_bit),
      .pt_valid  (pt_valid),
`ifdef ACORN_DECRYPT_EN
      .dec       (dec),
`endif
      .pt_ready  (pt_ready),
      .ct_bit    (ct_bit),
      .ct_valid  (ct_valid),
      .busy      (busy),
      .done      (done),
      .state_out (state_out)
   );

   // 100 MHz-style free running clock
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [292:0] observed, input logic [292:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic bit maj3(input bit a, input bit b, input bit c);
      return (int'(a) + int'(b) + int'(c)) >= 2;
   endfunction

   // One ACORN-128 state step on a plain bit array (cb is always 0 here);
   // returns the keystream bit, next state through nxt
   function automatic bit modelStep(input logic [292:0] cur, input bit m, input bit ca, output logic [292:0] nxt);
      int dst [6] = '{289, 230, 193, 154, 107, 61};
      int srcA[6] = '{235, 196, 160, 111, 66, 23};
      int srcB[6] = '{230, 193, 154, 107, 61, 0};
      bit s[293];
      bit ks;
      bit f;
      for (int i = 0; i < 293; i++) s[i] = cur[i];
      for (int k = 0; k < 6; k++) s[dst[k]] = s[dst[k]] ^ s[srcA[k]] ^ s[srcB[k]];
      ks = s[12] ^ s[154] ^ maj3(s[235], s[61], s[193]) ^ (s[230] ? s[111] : s[66]);
      f  = s[0] ^ !s[107] ^ maj3(s[244], s[23], s[160]) ^ (ca & s[196]) ^ m;
      for (int i = 0; i < 292; i++) nxt[i] = s[i + 1];
      nxt[292] = f;
      return ks;
   endfunction

   // Whole-message reference: ptMsg in, expCt and expFinal out
   task automatic modelRun(input logic [292:0] s0, input int len, input bit decMode);
      logic [292:0] s, nxt;
      bit ks, m;
      s = s0;
      for (int i = 0; i < len; i++) begin
         ks = modelStep(s, 1'b0, 1'b1, nxt);
         m  = decMode ? (ptMsg[i] ^ ks) : ptMsg[i];
         void'(modelStep(s, m, 1'b1, nxt));
         expCt[i] = ptMsg[i] ^ ks;
         s = nxt;
      end
      for (int j = 0; j < 256; j++) begin
         void'(modelStep(s, (j == 0), (j < 128), nxt));
         s = nxt;
      end
      expFinal = s;
   endtask

   function automatic logic [292:0] randState();
      logic [292:0] r;
      for (int i = 0; i < 293; i++) r[i] = 1'($urandom_range(1));
      return r;
   endfunction

   // Runs one message end to end. The task drives inputs on negedges, with
   // random stalls and stray start/pt_valid pulses, and checks every
   // ciphertext bit and the final state against the model.
   task automatic applyStimulus(input string name, input logic [292:0] s0, input int len,
                                input bit decMode, input int stallPct);
      int  edges, idx, ctIdx;
      bit  pvDriven, rdy, seenDone;
      modelRun(s0, len, decMode);
      @(negedge clk);
      start    = 1'b1;
      state_in = s0;
      pt_len   = len[LEN_W-1:0];
`ifdef ACORN_DECRYPT_EN
      dec      = decMode;
`endif
      @(negedge clk);
      start    = 1'b0;
      edges    = 1;
      idx      = 0;
      ctIdx    = 0;
      pvDriven = 1'b0;
      rdy      = 1'b0;
      seenDone = 1'b0;
      while (edges < 6000) begin
         if (ct_valid) begin
            if (ctIdx < len) checkOutput({name, " ct_bit"}, 293'(ct_bit), 293'(expCt[ctIdx]));
            else checkOutput({name, " extra ct_valid"}, 293'(ct_valid), 293'(0));
            ctIdx++;
         end
         if (done) begin
            seenDone = 1'b1;
            break;
         end
         if (pvDriven && rdy) idx++;
         rdy = pt_ready;
         if (pt_ready && idx < len && $urandom_range(99) >= stallPct) begin
            pt_valid = 1'b1;
            pt_bit   = ptMsg[idx];
         end else if (pt_ready) begin
            pt_valid = 1'b0;
            pt_bit   = 1'($urandom_range(1));
         end else begin
            pt_valid = 1'($urandom_range(1));
            pt_bit   = 1'($urandom_range(1));
         end
         pvDriven = pt_valid;
         start    = busy ? 1'($urandom_range(1)) : 1'b0;
         state_in = randState();
         pt_len   = LEN_W'($urandom);
         @(negedge clk);
         edges++;
      end
      start     = 1'b0;
      pt_valid  = 1'b0;
      lastEdges = edges;
      checkOutput({name, " done seen"}, 293'(seenDone), 293'(1));
      checkOutput({name, " ct count"}, 293'(ctIdx), 293'(len));
      checkOutput({name, " state_out"}, state_out, expFinal);
      checkOutput({name, " busy at done"}, 293'(busy), 293'(0));
      checkOutput({name, " pt_ready at done"}, 293'(pt_ready), 293'(0));
   endtask

   // Test sequence
   initial begin
      int len;
      logic [292:0] s;
      rst      = 1'b0;
      start    = 1'b0;
      pt_valid = 1'b0;
      pt_bit   = 1'b0;
      state_in = '0;
      pt_len   = '0;
`ifdef ACORN_DECRYPT_EN
      dec      = 1'b0;
`endif
      repeat (3) @(negedge clk);
      checkOutput("reset busy", 293'(busy), 293'(0));
      checkOutput("reset done", 293'(done), 293'(0));
      checkOutput("reset pt_ready", 293'(pt_ready), 293'(0));
      checkOutput("reset ct_valid", 293'(ct_valid), 293'(0));
      checkOutput("reset ct_bit", 293'(ct_bit), 293'(0));
      checkOutput("reset state_out", state_out, 293'(0));
      rst = 1'b1;

      // Empty message: start cycle plus 256 padding steps
      applyStimulus("zero_len0", '0, 0, 1'b0, 0);
      checkOutput("zero_len0 latency", 293'(lastEdges), 293'(257));

      // Single bit on zero state: keystream is 0 so ct equals pt
      ptMsg[0] = 1'b1;
      applyStimulus("zero_len1", '0, 1, 1'b0, 0);
      checkOutput("zero_len1 latency", 293'(lastEdges), 293'(258));

      // 128-bit random message, unstalled then heavily stalled
      savedState = randState();
      for (int i = 0; i < 128; i++) begin
         ptMsg[i]   = 1'($urandom_range(1));
         savedPt[i] = ptMsg[i];
      end
      applyStimulus("msg128", savedState, 128, 1'b0, 0);
      savedFinal = expFinal;
      for (int i = 0; i < 128; i++) savedCt[i] = expCt[i];
      applyStimulus("msg128_stall", savedState, 128, 1'b0, 50);
      checkOutput("msg128 stall final equals unstalled", state_out, savedFinal);

      // Reset in the middle of padding (counter 100)
      @(negedge clk);
      start    = 1'b1;
      state_in = randState();
      pt_len   = '0;
      @(negedge clk);
      start = 1'b0;
      repeat (100) @(negedge clk);
      checkOutput("mid-pad busy", 293'(busy), 293'(1));
      rst = 1'b0;
      #1;
      checkOutput("abort busy", 293'(busy), 293'(0));
      checkOutput("abort done", 293'(done), 293'(0));
      checkOutput("abort state_out", state_out, 293'(0));
      checkOutput("abort ct_valid", 293'(ct_valid), 293'(0));
      @(negedge clk);
      checkOutput("abort pt_ready", 293'(pt_ready), 293'(0));
      rst = 1'b1;
      for (int i = 0; i < 37; i++) ptMsg[i] = 1'($urandom_range(1));
      applyStimulus("after_reset", randState(), 37, 1'b0, 30);

      // Random lengths including the maximum message length
      for (int t = 0; t < 3; t++) begin
         len = (t == 0) ? 4095 : int'($urandom_range(300, 2));
         for (int i = 0; i < len; i++) ptMsg[i] = 1'($urandom_range(1));
         s = randState();
         applyStimulus("rand_len", s, len, 1'b0, 20);
      end

`ifdef ACORN_DECRYPT_EN
      // Decrypting the 128-bit ciphertext must give back plaintext and state
      for (int i = 0; i < 128; i++) ptMsg[i] = savedCt[i];
      applyStimulus("decrypt128", savedState, 128, 1'b1, 25);
      checkOutput("decrypt128 final equals encrypt final", state_out, savedFinal);
      for (int i = 0; i < 128; i++)
         checkOutput("decrypt128 model plaintext", 293'(expCt[i]), 293'(savedPt[i]));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
      $finish;
   end

   // Global time limit so the bench can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
